// File: rtl/arm_mem_pkg.sv
// Shared types for the two-port data-memory arbiter: port index, access-stage record, address check.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package arm_mem_pkg;

    localparam int unsigned MEM_WORDS_DEF = 64;

    typedef enum logic {
        PORT_CORE = 1'b0,
        PORT_DMA  = 1'b1
    } port_t;

    // One accepted request waiting for its memory cycle.
    typedef struct packed {
        logic        vld;
        port_t       port;
        logic        we;
        logic [31:0] adr;
        logic [31:0] wd;
        logic        err;
    } stage_t;

    // Misaligned or beyond the last word of a memory of 'words' 32-bit words.
    function automatic logic addr_err(input logic [31:0] adr, input int unsigned words);
        logic [33:0] lim;
        lim = 34'(words) << 2;
        return (adr[1:0] != 2'b00) || ({2'b00, adr} >= lim);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter: lone requester wins, ties go to the priority port, priority flips to the loser.
// Latency: grant is combinational from req and the priority flop (0 cycles).
// Backpressure: a port not granted simply keeps requesting; no grant while reset is low.
module rr_arbiter2
    import arm_mem_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    port_t prio;

    // Grant selection: single requester wins outright, a tie is broken by prio.
    always_comb begin
        gnt = 2'b00;
        if (reset) begin
            if (req == 2'b11) begin
                gnt = (prio == PORT_CORE) ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    // After serving port k the other port gets the next tie.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prio <= PORT_CORE;
        end else if (gnt[0]) begin
            prio <= PORT_DMA;
        end else if (gnt[1]) begin
            prio <= PORT_CORE;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data memory between the core (port 0) and the DMA/debug loader (port 1) through a one-entry access stage.
// Latency: accepted in cycle N, memory access and rvalid/rerr/rdata in cycle N+1; one request per cycle.
// Backpressure: an ungranted port holds its request; while reset is low nothing is granted and the stage is silent.
module dmem_arbiter
    import arm_mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [1:0]       we,
    input  logic [1:0][31:0] adr,
    input  logic [1:0][31:0] wd,
    output logic [1:0]       gnt,
    output logic [1:0]       rvalid,
    output logic [1:0]       rerr,
    output logic [31:0]      rdata,
    output logic             mem_we,
    output logic [31:0]      mem_a,
    output logic [31:0]      mem_wd,
    input  logic [31:0]      mem_rd
);

    stage_t st;
    stage_t st_nxt;
    logic   sel;
    logic   live;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .gnt   (gnt)
    );

    // Capture the granted port's request; an idle cycle loads an empty (all-zero) entry.
    always_comb begin
        st_nxt = '0;
        sel    = gnt[1];
        if (gnt != 2'b00) begin
            st_nxt.vld  = 1'b1;
            st_nxt.port = sel ? PORT_DMA : PORT_CORE;
            st_nxt.we   = we[sel];
            st_nxt.adr  = adr[sel];
            st_nxt.wd   = wd[sel];
            st_nxt.err  = addr_err(adr[sel], MEM_WORDS);
        end
    end

    // Access stage register; reset drops any in-flight entry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            st <= '0;
        end else begin
            st <= st_nxt;
        end
    end

    // Stage outputs are qualified by reset too, so an entry caught by reset never writes or completes.
    always_comb begin
        live   = st.vld & reset;
        mem_we = 1'b0;
        mem_a  = '0;
        mem_wd = '0;
        rvalid = 2'b00;
        rerr   = 2'b00;
        rdata  = '0;
        if (live) begin
            mem_we = st.we & ~st.err;
            mem_a  = st.adr;
            mem_wd = st.wd;
            rvalid = (st.port == PORT_DMA) ? 2'b10 : 2'b01;
            rerr   = st.err ? rvalid : 2'b00;
            rdata  = st.err ? 32'h0 : mem_rd;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vectors, a reference model of grant order and memory contents checked every cycle.
// Latency: n/a.
// Backpressure: n/a.
module tb_dmem_arbiter;

    localparam int unsigned MW = 64;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       req;
    logic [1:0]       we;
    logic [1:0][31:0] adr;
    logic [1:0][31:0] wd;
    logic [1:0]       gnt;
    logic [1:0]       rvalid;
    logic [1:0]       rerr;
    logic [31:0]      rdata;
    logic             mem_we;
    logic [31:0]      mem_a;
    logic [31:0]      mem_wd;
    logic [31:0]      mem_rd;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [MW];
    logic [31:0] ref_mem [MW];
    logic        mem_init;

    always #5 clk = ~clk;

    dmem_arbiter #(.MEM_WORDS(MW)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .we     (we),
        .adr    (adr),
        .wd     (wd),
        .gnt    (gnt),
        .rvalid (rvalid),
        .rerr   (rerr),
        .rdata  (rdata),
        .mem_we (mem_we),
        .mem_a  (mem_a),
        .mem_wd (mem_wd),
        .mem_rd (mem_rd)
    );

    function automatic logic [31:0] init_val(input int i);
        return 32'h1000_0000 + 32'(i);
    endfunction

    // Data memory: combinational read, write on the rising edge.
    assign mem_rd = (mem_a < 32'(4 * MW)) ? mem[mem_a[7:2]] : 32'h0;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < int'(MW); i++) mem[i] <= init_val(i);
        end else if (mem_we && mem_a < 32'(4 * MW)) begin
            mem[mem_a[7:2]] <= mem_wd;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: who wins, what is pending for next cycle, what memory holds.
    logic        last_dma;
    logic        p_vld;
    logic        p_port;
    logic        p_we;
    logic        p_err;
    logic [31:0] p_adr;
    logic [31:0] p_wd;

    initial begin
        last_dma = 1'b1;
        p_vld    = 1'b0;
        p_port   = 1'b0;
        p_we     = 1'b0;
        p_err    = 1'b0;
        p_adr    = '0;
        p_wd     = '0;
        for (int i = 0; i < int'(MW); i++) ref_mem[i] = init_val(i);
    end

    always @(negedge clk) begin
        logic [1:0]  eg;
        logic        live;
        logic        k;
        logic [1:0]  ev;
        eg = 2'b00;
        if (reset === 1'b1) begin
            if (req == 2'b11) eg = last_dma ? 2'b01 : 2'b10;
            else              eg = req;
        end
        live = p_vld && (reset === 1'b1);
        ev   = live ? (p_port ? 2'b10 : 2'b01) : 2'b00;
        chk("m_gnt",    gnt,    eg);
        chk("m_rvalid", rvalid, ev);
        chk("m_rerr",   rerr,   p_err ? ev : 2'b00);
        chk("m_mem_we", mem_we, live && p_we && !p_err);
        chk("m_mem_a",  mem_a,  live ? p_adr : 32'h0);
        chk("m_mem_wd", mem_wd, live ? p_wd : 32'h0);
        if (!(live && p_we))
            chk("m_rdata", rdata, (live && !p_err) ? ref_mem[p_adr[7:2]] : 32'h0);
        if (reset !== 1'b1) begin
            p_vld    = 1'b0;
            last_dma = 1'b1;
        end else begin
            if (live && p_we && !p_err) ref_mem[p_adr[7:2]] = p_wd;
            if (eg != 2'b00) begin
                k        = eg[1];
                p_vld    = 1'b1;
                p_port   = k;
                p_we     = we[k];
                p_adr    = adr[k];
                p_wd     = wd[k];
                p_err    = (adr[k] % 4 != 0) || (adr[k] / 4 >= MW);
                last_dma = k;
            end else begin
                p_vld = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    // Single-port boundary vectors: {port, we, adr, wd}
    typedef struct packed {
        logic        port;
        logic        we;
        logic [31:0] adr;
        logic [31:0] wd;
    } vec_t;

    vec_t vecs [6];
    logic [1:0] dual_gnt [5];

    initial begin
        vecs[0] = '{1'b0, 1'b1, 32'h0000_00FC, 32'hA5A5_0001};
        vecs[1] = '{1'b0, 1'b0, 32'h0000_00FC, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_00FD, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0};
        vecs[4] = '{1'b1, 1'b1, 32'h0000_0000, 32'h1234_5678};
        vecs[5] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0};
        dual_gnt[0] = 2'b01;
        dual_gnt[1] = 2'b10;
        dual_gnt[2] = 2'b01;
        dual_gnt[3] = 2'b10;
        dual_gnt[4] = 2'b01;

        reset    = 1'b0;
        req      = 2'b11;
        we       = 2'b00;
        adr      = '0;
        wd       = '0;
        mem_init = 1'b1;
        step();
        mem_init = 1'b0;
        at_neg();
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_mem_we", mem_we, 1'b0);

        // First cycle out of reset, nobody requesting: everything quiet.
        step();
        reset = 1'b1;
        req   = 2'b00;
        at_neg();
        chk("post_rst_ctl", {gnt, rvalid, rerr, mem_we}, 7'h0);
        chk("post_rst_dat", {rdata, mem_a}, 64'h0);
        chk("post_rst_wd", mem_wd, 32'h0);

        // Core write 0x64 = 7.
        step();
        req    = 2'b01;
        we     = 2'b01;
        adr[0] = 32'h64;
        wd[0]  = 32'h7;
        at_neg();
        chk("w64_gnt", gnt, 2'b01);
        step();
        req = 2'b00;
        we  = 2'b00;
        at_neg();
        chk("w64_mem_we", mem_we, 1'b1);
        chk("w64_mem_a", mem_a, 32'h64);
        chk("w64_mem_wd", mem_wd, 32'h7);
        chk("w64_rvalid", rvalid, 2'b01);
        chk("w64_rerr", rerr, 2'b00);

        // DMA write 0x60 then read it back on the next grant.
        step();
        req    = 2'b10;
        we     = 2'b10;
        adr[1] = 32'h60;
        wd[1]  = 32'hDEAD_BEEF;
        at_neg();
        chk("w60_gnt", gnt, 2'b10);
        step();
        we = 2'b00;
        at_neg();
        chk("r60_gnt", gnt, 2'b10);
        chk("w60_mem_we", mem_we, 1'b1);
        step();
        req = 2'b00;
        at_neg();
        chk("r60_rvalid", rvalid, 2'b10);
        chk("r60_rdata", rdata, 32'hDEAD_BEEF);

        // Out-of-range write then misaligned read on the core port.
        step();
        req    = 2'b01;
        we     = 2'b01;
        adr[0] = 32'h100;
        wd[0]  = 32'h55;
        step();
        we     = 2'b00;
        adr[0] = 32'h62;
        at_neg();
        chk("e100_mem_we", mem_we, 1'b0);
        chk("e100_rv_re", {rvalid, rerr}, 4'b0101);
        step();
        req = 2'b00;
        at_neg();
        chk("e62_mem_we", mem_we, 1'b0);
        chk("e62_rv_re", {rvalid, rerr}, 4'b0101);
        chk("e62_rdata", rdata, 32'h0);

        // Boundary addresses, one port at a time.
        for (int i = 0; i < 6; i++) begin
            step();
            req             = vecs[i].port ? 2'b10 : 2'b01;
            we              = vecs[i].we ? req : 2'b00;
            adr[vecs[i].port] = vecs[i].adr;
            wd[vecs[i].port]  = vecs[i].wd;
        end
        step();
        req = 2'b00;
        we  = 2'b00;
        at_neg();
        chk("r0_after_dma_w", rdata, 32'h1234_5678);

        // Both ports request continuously from reset release.
        step();
        reset = 1'b0;
        step();
        reset  = 1'b1;
        req    = 2'b11;
        we     = 2'b00;
        adr[0] = 32'h0;
        adr[1] = 32'h4;
        for (int i = 0; i < 5; i++) begin
            at_neg();
            chk("dual_gnt", gnt, dual_gnt[i]);
            chk("dual_rvalid", rvalid, (i == 0) ? 2'b00 : dual_gnt[i-1]);
            step();
        end
        req = 2'b00;
        at_neg();
        chk("dual_last_rvalid", rvalid, 2'b01);

        // Reset lands while the stage holds a DMA write 0x10 = 5.
        step();
        req    = 2'b10;
        we     = 2'b10;
        adr[1] = 32'h10;
        wd[1]  = 32'h5;
        at_neg();
        chk("w10_gnt", gnt, 2'b10);
        step();
        reset  = 1'b0;
        req    = 2'b11;
        we     = 2'b00;
        adr[0] = 32'h8;
        adr[1] = 32'hC;
        at_neg();
        chk("w10_rst_mem_we", mem_we, 1'b0);
        chk("w10_rst_rvalid", rvalid, 2'b00);
        chk("w10_rst_gnt", gnt, 2'b00);
        step();
        reset = 1'b1;
        at_neg();
        chk("w10_after_gnt", gnt, 2'b01);
        chk("w10_after_rvalid", rvalid, 2'b00);
        step();
        req = 2'b00;
        at_neg();
        chk("w10_after_r8", {rvalid, rdata}, {2'b01, 32'h1000_0002});
        step();
        step();
        chk("w10_word4", mem[4], 32'h1000_0004);
        chk("w60_word24", mem[24], 32'hDEAD_BEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter MEM_WORDS, default 64, number of 32-bit words in the shared data memory; legal byte addresses are 0 to 4*MEM_WORDS-4.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-004 req  input  2  per-port request valid; port 0 = core data side, port 1 = DMA/debug loader.
REQ-005 we  input  2  per-port write enable (1 = write, 0 = read).
REQ-006 adr  input  2x32  per-port byte address.
REQ-007 wd  input  2x32  per-port write data.
REQ-008 gnt  output  2  per-port grant; a request is accepted in any cycle where req[i]&gnt[i]=1.
REQ-009 rvalid  output  2  per-port completion strobe, one cycle per accepted request (reads and writes).
REQ-010 rerr  output  2  per-port error flag, valid only with rvalid[i].
REQ-011 rdata  output  32  read data shared by both ports, qualified by rvalid[i] of a read.
REQ-012 mem_we  output  1  memory write enable.
REQ-013 mem_a  output  32  memory byte address.
REQ-014 mem_wd  output  32  memory write data.
REQ-015 mem_rd  input  32  memory combinational read data for mem_a.

Function
REQ-016 At most one bit of gnt is 1 in any cycle; gnt is combinational from req and the priority register.
REQ-017 Only one port requesting: that port is granted in the same cycle.
REQ-018 Both ports requesting: grant goes to the port indicated by the priority register; after any grant to port k, priority moves to port 1-k.
REQ-019 Accepted request is registered into a one-entry access stage (valid, port, we, adr, wd, err); a new request can be accepted every cycle (throughput 1/cycle).
REQ-020 Cycle after acceptance (N+1): stage drives mem_a=adr, mem_wd=wd, mem_we=we&~err; rvalid[port]=1, rerr[port]=err, rdata=mem_rd.
REQ-021 Latency: acceptance in cycle N, write committed at the rising edge ending cycle N+1, read data on rdata in cycle N+1.
REQ-022 err=1 when adr[1:0]!=0 or adr>=4*MEM_WORDS; an erroneous write never asserts mem_we; an erroneous read returns rdata=0.
REQ-023 Stage empty: mem_we=0, mem_a=0, mem_wd=0, rvalid=0, rerr=0, rdata=0.
REQ-024 Requesters hold req, we, adr, wd stable until granted; the arbiter never withdraws a grant once given in a cycle.
REQ-025 Transactions complete in grant order; write then read to the same address in consecutive grants returns the new data.

Reset
REQ-026 While reset=0: gnt=0, mem_we=0 combinationally, no request accepted.
REQ-027 At a rising edge with reset=0: stage valid cleared, priority register set to port 0; an in-flight stage entry is discarded with no memory write and no rvalid.
REQ-028 All outputs are 0 in the first cycle after reset deasserts.

Structure
REQ-029 Package arm_mem_pkg holds MEM_WORDS default, port-index typedef (PORT_CORE=0, PORT_DMA=1) and the access-stage struct typedef.
REQ-030 Sub-module rr_arbiter2 (two-input round-robin: req, priority flop, gnt) is instantiated once; stage and error check live in dmem_arbiter.

Verification
REQ-031 Port0 write adr=0x64 wd=7 alone -> gnt[0] cycle N; cycle N+1 mem_we=1, mem_a=0x64, mem_wd=7, rvalid[0]=1, rerr[0]=0.
REQ-032 Both ports request continuously from reset release -> grants 0,1,0,1; each port's rvalid one cycle after its grant.
REQ-033 Port1 write 0x60=0xDEADBEEF then read 0x60 back-to-back -> second rvalid[1] with rdata=0xDEADBEEF.
REQ-034 Port0 write adr=0x100 and read adr=0x62 -> mem_we stays 0, rvalid[0]=1 with rerr[0]=1 both times, rdata=0 on the read.
REQ-035 reset=0 in the cycle the stage holds port1 write 0x10=5 -> mem_we=0, no rvalid, memory word 4 unchanged; next dual request granted to port 0.
